knn_topk_ctrl: RTL and testbench

- Parametrised successor to the single-neighbour KNN control FSM.
- Accepts a stream of (distance, label) candidates for one test point over a valid/ready handshake.
- Maintains a sorted list of the K nearest candidates by in-place insertion, one compare/shift per cycle.
- Signals completion after a programmed number of data points; sits between the distance datapath and the vote/classification logic.

---
 rtl/knn_topk_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_knn_topk_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_ctrl.sv
// K-nearest-neighbour list controller: keeps the K smallest (distance, label)
// candidates of one test point sorted by one-compare-per-cycle insertion.
module knn_topk_ctrl #(
    parameter int unsigned K       = 4,
    parameter int unsigned DIST_W  = 32,
    parameter int unsigned LABEL_W = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned IDX_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_points,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    output logic               busy,
    output logic               done,
    output logic [IDX_W:0]     n_fill,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_occ
);

    localparam logic [IDX_W-1:0] P_LAST   = IDX_W'(K - 1);
    localparam logic [IDX_W:0]   FILL_MAX = (IDX_W + 1)'(K);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DIST_W-1:0]    r_dist  [K];
    logic [LABEL_W-1:0]   r_label [K];
    logic                 r_occ   [K];

    logic [DIST_W-1:0]    r_hold_dist;
    logic [LABEL_W-1:0]   r_hold_label;
    logic [IDX_W-1:0]     r_p;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_rem;
    logic [IDX_W:0]       r_fill;

    logic [IDX_W-1:0]     w_p1;
    logic                 w_less;
    logic                 w_accept;
    logic                 w_shift;
    logic                 w_ins_here;
    logic                 w_ins_next;
    logic                 w_dec;
    logic                 w_end;
    logic                 w_fill_inc;

    assign w_p1   = r_p + IDX_W'(1);
    // Unoccupied entries compare as +infinity; strict less keeps ties stable.
    assign w_less = !r_occ[r_p] || (r_hold_dist < r_dist[r_p]);

    // Next-state and per-cycle datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_ins_here  = 1'b0;
        w_ins_next  = 1'b0;
        w_dec       = 1'b0;
        w_end       = 1'b0;
        w_fill_inc  = 1'b0;

        case (r_state)
            S_WAIT: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_less) begin
                    w_shift = (r_p != P_LAST);
                    if (r_p == '0) begin
                        w_ins_here = 1'b1;
                        w_end      = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end else begin
                    w_ins_next = (r_p != P_LAST);
                    w_end      = 1'b1;
                end
                if (w_end) begin
                    w_state_nxt = (r_cnt == r_rem) ? S_DONE : S_WAIT;
                end
            end
            default: ;
        endcase

        w_fill_inc = (w_shift && r_occ[r_p] && !r_occ[w_p1]) ||
                     (w_ins_here && !r_occ[r_p]) ||
                     (w_ins_next && !r_occ[w_p1]);

        if (start) begin
            w_state_nxt = (n_points == '0) ? S_DONE : S_WAIT;
        end
    end

    // State register, list storage and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hold_dist  <= '0;
            r_hold_label <= '0;
            r_p          <= '0;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_fill       <= '0;
            for (int i = 0; i < int'(K); i++) begin
                r_dist[i]  <= '0;
                r_label[i] <= '0;
                r_occ[i]   <= 1'b0;
            end
        end else if (start) begin
            r_state <= w_state_nxt;
            r_cnt   <= '0;
            r_rem   <= n_points;
            r_fill  <= '0;
            for (int i = 0; i < int'(K); i++) begin
                r_dist[i]  <= '0;
                r_label[i] <= '0;
                r_occ[i]   <= 1'b0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_hold_dist  <= in_dist;
                r_hold_label <= in_label;
                r_p          <= P_LAST;
                r_cnt        <= r_cnt + CNT_W'(1);
            end
            if (w_dec) begin
                r_p <= r_p - IDX_W'(1);
            end
            if (w_shift) begin
                r_dist[w_p1]  <= r_dist[r_p];
                r_label[w_p1] <= r_label[r_p];
                r_occ[w_p1]   <= r_occ[r_p];
            end
            if (w_ins_here) begin
                r_dist[r_p]  <= r_hold_dist;
                r_label[r_p] <= r_hold_label;
                r_occ[r_p]   <= 1'b1;
            end
            if (w_ins_next) begin
                r_dist[w_p1]  <= r_hold_dist;
                r_label[w_p1] <= r_hold_label;
                r_occ[w_p1]   <= 1'b1;
            end
            if (w_fill_inc && (r_fill < FILL_MAX)) begin
                r_fill <= r_fill + (IDX_W + 1)'(1);
            end
        end
    end

    assign in_ready = (r_state == S_WAIT);
    assign busy     = (r_state == S_WAIT) || (r_state == S_SCAN);
    assign done     = (r_state == S_DONE);
    assign n_fill   = r_fill;

    // Read port, usable in every state
    always_comb begin
        rd_dist  = '0;
        rd_label = '0;
        rd_occ   = 1'b0;
        if ({1'b0, rd_idx} < FILL_MAX) begin
            rd_dist  = r_dist[rd_idx];
            rd_label = r_label[rd_idx];
            rd_occ   = r_occ[rd_idx];
        end
    end

endmodule

// File: tb/tb_knn_topk_ctrl.sv
// Directed bench for knn_topk_ctrl: a stable insertion-sort reference list
// feeds a scoreboard queue that is drained through the read port.
module tb_knn_topk_ctrl;

    localparam int unsigned K  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        logic          o;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] n_points = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_dist = '0;
    logic [LW-1:0] in_label = '0;
    logic          busy;
    logic          done;
    logic [IW:0]   n_fill;
    logic [IW-1:0] rd_idx = '0;
    logic [DW-1:0] rd_dist;
    logic [LW-1:0] rd_label;
    logic          rd_occ;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_dist [K];
    logic [LW-1:0] m_lab  [K];
    int            m_n;
    ent_t          sb [$];

    knn_topk_ctrl #(.K(K), .DIST_W(DW), .LABEL_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
        .in_label(in_label), .busy(busy), .done(done), .n_fill(n_fill),
        .rd_idx(rd_idx), .rd_dist(rd_dist), .rd_label(rd_label), .rd_occ(rd_occ)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < int'(K); i++) begin
            m_dist[i] = '0;
            m_lab[i]  = '0;
        end
        m_n = 0;
    endtask

    task automatic m_ins(input logic [DW-1:0] d, input logic [LW-1:0] l);
        int pos;
        pos = m_n;
        for (int i = m_n - 1; i >= 0; i--) if (d < m_dist[i]) pos = i;
        if (pos < int'(K)) begin
            for (int j = int'(K) - 1; j > pos; j--) begin
                m_dist[j] = m_dist[j-1];
                m_lab[j]  = m_lab[j-1];
            end
            m_dist[pos] = d;
            m_lab[pos]  = l;
            if (m_n < int'(K)) m_n++;
        end
    endtask

    // Expected list enters the scoreboard, then is drained via the read port
    task automatic check_list(input string tag);
        ent_t e;
        for (int i = 0; i < int'(K); i++) sb.push_back({m_dist[i], m_lab[i], (i < m_n)});
        for (int i = 0; i < int'(K); i++) begin
            e = sb.pop_front();
            rd_idx = IW'(i);
            #1;
            chk($sformatf("%s_dist%0d", tag, i), 64'(rd_dist), 64'(e.d));
            chk($sformatf("%s_lab%0d", tag, i), 64'(rd_label), 64'(e.l));
            chk($sformatf("%s_occ%0d", tag, i), 64'(rd_occ), 64'(e.o));
        end
        chk({tag, "_nfill"}, 64'(n_fill), 64'(m_n));
    endtask

    task automatic start_tp(input logic [CW-1:0] n);
        start = 1'b1;
        n_points = n;
        m_clear();
        tick();
        start = 1'b0;
    endtask

    // Offer one candidate; if complete, wait out its scan and model it
    task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input bit complete);
        int w;
        int s;
        in_dist = d;
        in_label = l;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_wait", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        if (complete) begin
            m_ins(d, l);
            s = 0;
            while (!in_ready && !done && s < 20) begin
                s++;
                tick();
            end
            chk("scan_len_1_to_K", 64'(s >= 1 && s <= int'(K)), 64'd1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        rd_idx = '0;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_nfill"}, 64'(n_fill), 64'd0);
        chk({tag, "_occ0"}, 64'(rd_occ), 64'd0);
        chk({tag, "_dist0"}, 64'(rd_dist), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] d6 [6];
        int   acc;
        int   run;
        int   cyc;
        logic [LW-1:0] lab;

        d6[0] = 50; d6[1] = 20; d6[2] = 80; d6[3] = 20; d6[4] = 10; d6[5] = 90;

        // Reset
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b1;
        tick();

        // Six candidates with a tie and two evictions
        start_tp(16'd6);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 6; i++) send(d6[i], LW'(i + 1), 1'b1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_low", 64'(busy), 64'd0);
        check_list("t1");

        // Two candidates, partial fill
        start_tp(16'd2);
        send(32'd7, 8'd1, 1'b1);
        send(32'd3, 8'd2, 1'b1);
        chk("t2_done", 64'(done), 64'd1);
        check_list("t2");

        // in_valid held high with data changing every cycle
        start_tp(16'd8);
        m_clear();
        in_valid = 1'b1;
        in_dist = 32'($urandom_range(0, 200));
        in_label = 8'd100;
        acc = 0;
        run = 0;
        cyc = 0;
        lab = 8'd100;
        while (cyc < 200) begin
            if (in_ready) begin
                chk("t3_ready_implies_busy", 64'(busy), 64'd1);
                if (acc > 0) chk("t3_scan_len", 64'(run >= 1 && run <= int'(K)), 64'd1);
                run = 0;
                m_ins(in_dist, in_label);
                acc++;
            end else if (busy) begin
                run++;
            end
            if (done) break;
            tick();
            cyc++;
            lab = lab + 8'd1;
            in_dist = 32'($urandom_range(0, 200));
            in_label = lab;
        end
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_last_scan_len", 64'(run >= 1 && run <= int'(K)), 64'd1);
        chk("t3_accepted", 64'(acc), 64'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_no_ready_in_done", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check_list("t3");

        // Zero data points
        start_tp(16'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_nfill", 64'(n_fill), 64'd0);
        tick();
        chk("t4_in_ready_hold", 64'(in_ready), 64'd0);

        // start during the 3rd candidate's scan drops it
        start_tp(16'd5);
        send(32'd40, 8'd11, 1'b1);
        send(32'd60, 8'd12, 1'b1);
        send(32'd5, 8'd99, 1'b0);
        chk("t5_in_scan", 64'({in_ready, busy}), 64'b01);
        start_tp(16'd3);
        chk("t5_wait_ready", 64'(in_ready), 64'd1);
        chk("t5_nfill", 64'(n_fill), 64'd0);
        rd_idx = '0;
        #1;
        chk("t5_occ0", 64'(rd_occ), 64'd0);
        send(32'd30, 8'd21, 1'b1);
        send(32'd25, 8'd22, 1'b1);
        chk("t5_not_done_early", 64'(done), 64'd0);
        send(32'd35, 8'd23, 1'b1);
        chk("t5_done", 64'(done), 64'd1);
        check_list("t5");

        // Reset mid-scan
        start_tp(16'd4);
        send(32'd9, 8'd31, 1'b1);
        send(32'd8, 8'd32, 1'b0);
        rst = 1'b0;
        tick();
        chk_reset_vals("t6a");
        rst = 1'b1;

        // Reset and start together mid-scan: reset wins
        start_tp(16'd4);
        send(32'd9, 8'd41, 1'b1);
        send(32'd8, 8'd42, 1'b0);
        rst = 1'b0;
        start = 1'b1;
        n_points = 16'd3;
        tick();
        start = 1'b0;
        chk_reset_vals("t6b");
        rst = 1'b1;
        tick();
        chk("t6b_idle_hold", 64'({in_ready, busy, done}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
